fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control unit (cu).
- Drives the word address of the instruction read port on dumbMem (port 2) and accepts the instruction word that returns one cycle later (registered read).
- Buffers fetched words in a small FIFO and presents them to cu with a valid/ready handshake.
- Handles jump redirects: flushes the buffer and squashes any in-flight read.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, word width
// and the FIFO entry layout.
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REDIRECT
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched instructions. Head read is combinational
// and reads as zero when empty; flush beats push.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail;
  logic             empty, do_pop, do_push;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = empty ? '0 : mem[head];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset because empty gates the head read.
  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[tail] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the control unit. Issues word reads to
// memory port 2, buffers returning words with their PC, handles jump redirects.
// Optional counters stat_fetched/stat_stall are built when FETCH_STATS_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              jump_en,
  input  logic [31:0]       jump_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [31:0]       mem_data,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stall
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc, inflight_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic          credit_ok, push, pop;
  fetch_entry_t  wentry, head;

  // Credit counts both stored entries and the read still in flight, so a
  // push can never meet a full FIFO.
  assign credit_ok   = (32'(count) + 32'(inflight)) < 32'(DEPTH);
  assign mem_req     = (state == S_RUN) && credit_ok && !jump_en;
  assign mem_addr    = fetch_pc[ADDR_W-1:0];
  assign push        = inflight && !jump_en;
  assign pop         = instr_valid && instr_ready;
  assign instr_valid = (count != '0);
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;
  assign wentry      = '{instr: mem_data, pc: inflight_pc};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (jump_en),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  // Fetch FSM and PC: a jump from any state squashes the in-flight read and
  // spends one redirect cycle before fetching resumes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (jump_en) begin
      state    <= S_REDIRECT;
      fetch_pc <= jump_target;
      inflight <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          inflight <= mem_req;
          if (mem_req) begin
            fetch_pc    <= fetch_pc + 32'd1;
            inflight_pc <= fetch_pc;
          end
        end
        default: begin
          state    <= S_RUN;
          inflight <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating statistics; jumps leave them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (push && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
      if (state == S_RUN && !instr_valid && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random
// ready/jump traffic, checked against a stream-order reference model.
module tb_fetch_unit;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              jump_en = 1'b0;
  logic [31:0]       jump_target = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic [31:0]       mem_data = '0;
  logic [31:0]       instr_out, instr_pc;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [31:0]       stat_fetched, stat_stall;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clock       (clock),
    .reset       (reset),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_data    (mem_data),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clock = ~clock;

  // Memory: mem[k] = A000_0000 + k, one-cycle registered read; garbage otherwise.
  always @(posedge clock)
    mem_data <= mem_req ? (32'hA000_0000 + {22'b0, mem_addr}) : $urandom;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = '0;   // next PC the consumer should see
  int          occ = 0;       // requests issued since flush minus entries consumed
  logic        last_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample what will happen at the coming edge, update the model, advance one cycle.
  task automatic tick();
    #1;
    last_req = mem_req;
    if (reset) begin
      exp_pc = 32'd0;
      occ    = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        chk("pop_pc", instr_pc, exp_pc);
        chk("pop_instr", instr_out, 32'hA000_0000 + {22'b0, exp_pc[9:0]});
        exp_pc = exp_pc + 32'd1;
        occ--;
      end
      if (mem_req) occ++;
      if (jump_en) begin
        chk("jump_noreq", {31'b0, mem_req}, 32'd0);
        exp_pc = jump_target;
        occ    = 0;
      end
      chk("credit", {31'b0, (occ <= DEPTH)}, 32'd1);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int nreq;
    @(negedge clock);
    // Reset state
    reset = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    #1;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);

    // Startup latency and streaming throughput
    reset = 1'b0;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (w == 0) chk("lat_w0_req", {31'b0, mem_req}, 32'd0);
      if (w == 1) chk("lat_w1_req", {31'b0, mem_req}, 32'd1);
      if (w < 3)  chk("lat_novalid", {31'b0, instr_valid}, 32'd0);
      else        chk("stream_valid", {31'b0, instr_valid}, 32'd1);
      if (w == 3) chk("first_pc", instr_pc, 32'd0);
      tick();
    end
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, 32'd18);
    chk("stat_stall", stat_stall, 32'd2);
`endif

    // Backpressure: at most DEPTH reads issued, then delivered in order
    jump_en = 1'b1; jump_target = 32'h100; instr_ready = 1'b0;
    tick();
    jump_en = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nreq += int'(last_req);
    end
    #1;
    chk("stall_nreq", nreq, DEPTH);
    chk("stall_req", {31'b0, mem_req}, 32'd0);
    chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    chk("stall_head", instr_pc, 32'h100);
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_drain", {31'b0, exp_pc >= 32'h108}, 32'd1);

    // Jump while 3 entries are held and a read is in flight
    jump_en = 1'b1; jump_target = 32'h200; instr_ready = 1'b0;
    tick();
    jump_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("pre_jump_valid", {31'b0, instr_valid}, 32'd1);
    chk("pre_jump_full", {31'b0, mem_req}, 32'd0);
    jump_en = 1'b1; jump_target = 32'h40;
    tick();
    jump_en = 1'b0;
    #1;
    chk("post_jump_valid", {31'b0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("jump_progress", {31'b0, exp_pc >= 32'h44}, 32'd1);

    // Address wrap: mem_addr wraps, instr_pc keeps counting
    jump_en = 1'b1; jump_target = 32'h3FE;
    tick();
    jump_en = 1'b0;
    tick();
    #1; chk("wrap_a0", {22'b0, mem_addr}, 32'h3FE);
    tick();
    #1; chk("wrap_a1", {22'b0, mem_addr}, 32'h3FF);
    tick();
    #1; chk("wrap_a2", {22'b0, mem_addr}, 32'h000);
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_progress", {31'b0, exp_pc > 32'h400}, 32'd1);

    // Reset mid-stream with two entries buffered
    jump_en = 1'b1; jump_target = 32'h80; instr_ready = 1'b0;
    tick();
    jump_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mrst_req", {31'b0, mem_req}, 32'd0);
    chk("mrst_addr", {22'b0, mem_addr}, 32'd0);
    chk("mrst_instr", instr_out, 32'd0);
    chk("mrst_pc", instr_pc, 32'd0);

    // Random ready and jump traffic
    for (int i = 0; i < 500; i++) begin
      instr_ready = ($urandom_range(3) != 0);
      jump_en     = ($urandom_range(19) == 0);
      jump_target = $urandom;
      tick();
    end
    jump_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
